// File: rtl/dp_mem_responder.sv
// Memory-side responder: arbitrates datapath fetch and load/store requests onto
// one single-port RAM port and returns single-cycle ihit/dhit pulses.
module dp_mem_responder #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IREQ   = 3'd1,
    S_DREQ   = 3'd2,
    S_IRESP  = 3'd3,
    S_DRESP  = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      iload_q, iload_d;
  logic [31:0]      dload_q, dload_d;
  logic             wr_q, wr_d;
  logic             ifirst_q, ifirst_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dgrant;
  logic             done;
  logic [31:0]      ld_val;

  // Wait counter never wraps past the limit, so a stuck RAM cannot alias back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= WAIT_LIM) ? c : c + CNT_W'(1);
  endfunction

  // Data wins the arbitration unless the instruction side is owed a turn.
  assign dgrant = (dmemREN | dmemWEN) & ~(ifirst_q & imemREN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      wr_q     <= 1'b0;
      ifirst_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      wr_q     <= wr_d;
      ifirst_q <= ifirst_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    wr_d     = wr_q;
    ifirst_d = ifirst_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    ld_val   = '0;
    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (dgrant) begin
          state_d = S_DREQ;
          addr_d  = {dmemaddr[31:2], 2'b00};
          wdata_d = dmemstore;
          wr_d    = dmemWEN;
          cnt_d   = '0;
          if (dmemaddr[1:0] != 2'b00) err_d = 1'b1;
        end else if (imemREN) begin
          state_d = S_IREQ;
          addr_d  = {imemaddr[31:2], 2'b00};
          wdata_d = '0;
          wr_d    = 1'b0;
          cnt_d   = '0;
          if (imemaddr[1:0] != 2'b00) err_d = 1'b1;
        end
      end
      S_IREQ, S_DREQ: begin
        if (ramstate == RAM_ACCESS) begin
          done   = 1'b1;
          ld_val = wr_q ? 32'h0 : ramload;
        end else if (ramstate == RAM_ERROR) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_d >= WAIT_LIM) begin
            done  = 1'b1;
            err_d = 1'b1;
          end
        end
        if (done) begin
          if (state_q == S_IREQ) begin
            state_d = S_IRESP;
            iload_d = ld_val;
          end else begin
            state_d = S_DRESP;
            dload_d = ld_val;
          end
        end
      end
      S_IRESP: begin
        ifirst_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_DRESP: begin
        ifirst_d = 1'b1;
        state_d  = S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ihit   = 1'b0;
    dhit   = 1'b0;
    case (state_q)
      S_IREQ, S_DREQ: begin
        ramREN = ~wr_q;
        ramWEN = wr_q;
      end
      S_IRESP: ihit = 1'b1;
      S_DRESP: dhit = 1'b1;
      default: ;
    endcase
  end

  assign ramaddr  = addr_q;
  assign ramstore = wdata_q;
  assign imemload = iload_q;
  assign dmemload = dload_q;
  assign mem_err  = err_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed bench for dp_mem_responder: per-cycle vector table plus hand-written
// sequences for timeout, RAM error, misalignment, halt and mid-access reset.
module tb_dp_mem_responder;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, RERR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN, dmemREN, dmemWEN, halt;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, mem_err;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;

  int ntests = 0;
  int nfail  = 0;

  dp_mem_responder #(.MAX_WAIT(15)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        eih, edh, eren, ewen;
    logic [31:0] eaddr, estore, eload;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic iren, dren, dwen,
                              input logic [31:0] ia, da, ds,
                              input logic [1:0] rs, input logic [31:0] rl,
                              input logic eih, edh, eren, ewen,
                              input logic [31:0] eaddr, estore, eload);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.ia = ia; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
    v.eih = eih; v.edh = edh; v.eren = eren; v.ewen = ewen;
    v.eaddr = eaddr; v.estore = estore; v.eload = eload;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(input logic iren, dren, dwen, input logic [31:0] ia, da, ds,
                       input logic h, input logic [1:0] rs, input logic [31:0] rl);
    @(posedge CLK);
    #1;
    imemREN = iren; dmemREN = dren; dmemWEN = dwen;
    imemaddr = ia; dmemaddr = da; dmemstore = ds;
    halt = h; ramstate = rs; ramload = rl;
    @(negedge CLK);
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, FREE, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramstate = FREE; ramload = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramstate = FREE; ramload = '0;

    // Fetch with immediate ACCESS
    tv.push_back(mk(1,0,0, 32'h0,0,0, FREE,0,            0,0,0,0, 32'h0,0,0));
    tv.push_back(mk(1,0,0, 32'h0,0,0, ACC,32'h11112222,  0,0,1,0, 32'h0,0,0));
    tv.push_back(mk(1,0,0, 32'h0,0,0, FREE,0,            1,0,0,0, 0,0,32'h11112222));
    tv.push_back(mk(0,0,0, 0,0,0,     FREE,0,            0,0,0,0, 0,0,0));
    // Simultaneous fetch and load: data first, then fetch
    tv.push_back(mk(1,1,0, 32'h40,32'h80,0, FREE,0,           0,0,0,0, 0,0,0));
    tv.push_back(mk(1,1,0, 32'h40,32'h80,0, ACC,32'hAAAA0001, 0,0,1,0, 32'h80,0,0));
    tv.push_back(mk(1,1,0, 32'h40,32'h80,0, FREE,0,           0,1,0,0, 0,0,32'hAAAA0001));
    tv.push_back(mk(1,0,0, 32'h40,0,0,      FREE,0,           0,0,0,0, 0,0,0));
    tv.push_back(mk(1,0,0, 32'h40,0,0,      ACC,32'hBBBB0002, 0,0,1,0, 32'h40,0,0));
    tv.push_back(mk(1,0,0, 32'h40,0,0,      FREE,0,           1,0,0,0, 0,0,32'hBBBB0002));
    tv.push_back(mk(0,0,0, 0,0,0,           FREE,0,           0,0,0,0, 0,0,0));
    // Back-to-back loads with a pending fetch: D,I,D,I
    tv.push_back(mk(1,1,0, 32'h8,32'h300,0, ACC,32'hD0, 0,0,0,0, 0,0,0));
    tv.push_back(mk(1,1,0, 32'h8,32'h300,0, ACC,32'hD0, 0,0,1,0, 32'h300,0,0));
    tv.push_back(mk(1,1,0, 32'h8,32'h300,0, ACC,32'hD0, 0,1,0,0, 0,0,32'hD0));
    tv.push_back(mk(1,1,0, 32'h8,32'h304,0, ACC,32'h10, 0,0,0,0, 0,0,0));
    tv.push_back(mk(1,1,0, 32'h8,32'h304,0, ACC,32'h10, 0,0,1,0, 32'h8,0,0));
    tv.push_back(mk(1,1,0, 32'h8,32'h304,0, ACC,32'h10, 1,0,0,0, 0,0,32'h10));
    tv.push_back(mk(1,1,0, 32'hC,32'h304,0, ACC,32'hD1, 0,0,0,0, 0,0,0));
    tv.push_back(mk(1,1,0, 32'hC,32'h304,0, ACC,32'hD1, 0,0,1,0, 32'h304,0,0));
    tv.push_back(mk(1,1,0, 32'hC,32'h304,0, ACC,32'hD1, 0,1,0,0, 0,0,32'hD1));
    tv.push_back(mk(1,1,0, 32'hC,32'h308,0, ACC,32'h11, 0,0,0,0, 0,0,0));
    tv.push_back(mk(1,1,0, 32'hC,32'h308,0, ACC,32'h11, 0,0,1,0, 32'hC,0,0));
    tv.push_back(mk(1,1,0, 32'hC,32'h308,0, ACC,32'h11, 1,0,0,0, 0,0,32'h11));
    tv.push_back(mk(0,0,0, 0,0,0,           FREE,0,     0,0,0,0, 0,0,0));
    // Store (REN+WEN together) with 3 BUSY cycles; inputs change mid-access
    tv.push_back(mk(0,1,1, 0,32'h100,32'hDEADBEEF, FREE,0,           0,0,0,0, 0,0,0));
    tv.push_back(mk(0,1,1, 0,32'h100,32'hDEADBEEF, BUSY,0,           0,0,0,1, 32'h100,32'hDEADBEEF,0));
    tv.push_back(mk(0,1,1, 0,32'h200,32'h0,        BUSY,0,           0,0,0,1, 32'h100,32'hDEADBEEF,0));
    tv.push_back(mk(0,1,1, 0,32'h100,32'hDEADBEEF, BUSY,0,           0,0,0,1, 32'h100,32'hDEADBEEF,0));
    tv.push_back(mk(0,1,1, 0,32'h100,32'hDEADBEEF, ACC,32'h12345678, 0,0,0,1, 32'h100,32'hDEADBEEF,0));
    tv.push_back(mk(0,1,1, 0,32'h100,32'hDEADBEEF, FREE,0,           0,1,0,0, 0,0,32'h0));
    tv.push_back(mk(0,0,0, 0,0,0,                  FREE,0,           0,0,0,0, 0,0,0));

    // Reset state
    @(negedge CLK);
    chk("rst ihit", ihit, 0);       chk("rst dhit", dhit, 0);
    chk("rst ramREN", ramREN, 0);   chk("rst ramWEN", ramWEN, 0);
    chk("rst mem_err", mem_err, 0); chk("rst imemload", imemload, 0);
    chk("rst dmemload", dmemload, 0); chk("rst ramaddr", ramaddr, 0);
    chk("rst ramstore", ramstore, 0);
    RST = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].iren, tv[i].dren, tv[i].dwen, tv[i].ia, tv[i].da, tv[i].ds,
            1'b0, tv[i].rs, tv[i].rl);
      chk($sformatf("v%0d ihit", i), ihit, tv[i].eih);
      chk($sformatf("v%0d dhit", i), dhit, tv[i].edh);
      chk($sformatf("v%0d ramREN", i), ramREN, tv[i].eren);
      chk($sformatf("v%0d ramWEN", i), ramWEN, tv[i].ewen);
      chk($sformatf("v%0d mem_err", i), mem_err, 0);
      if (tv[i].eren || tv[i].ewen) chk($sformatf("v%0d ramaddr", i), ramaddr, tv[i].eaddr);
      if (tv[i].ewen) chk($sformatf("v%0d ramstore", i), ramstore, tv[i].estore);
      if (tv[i].eih) chk($sformatf("v%0d imemload", i), imemload, tv[i].eload);
      if (tv[i].edh) chk($sformatf("v%0d dmemload", i), dmemload, tv[i].eload);
    end

    // Misaligned load: word-aligned RAM address, error flag raised at grant
    drive(0,1,0, 0,32'h103,0, 0, ACC,32'h5A);
    drive(0,1,0, 0,32'h103,0, 0, ACC,32'h5A);
    chk("mis ramREN", ramREN, 1);
    chk("mis ramaddr", ramaddr, 32'h100);
    chk("mis mem_err", mem_err, 1);
    drive(0,1,0, 0,32'h103,0, 0, FREE,0);
    chk("mis dhit", dhit, 1);
    chk("mis dmemload", dmemload, 32'h5A);
    do_reset();
    chk("mis err cleared", mem_err, 0);

    // RAM ERROR during a fetch
    drive(1,0,0, 32'h44,0,0, 0, FREE,0);
    drive(1,0,0, 32'h44,0,0, 0, RERR,32'h77);
    chk("err ramREN", ramREN, 1);
    drive(1,0,0, 32'h44,0,0, 0, FREE,0);
    chk("err ihit", ihit, 1);
    chk("err imemload", imemload, 0);
    chk("err mem_err", mem_err, 1);
    do_reset();

    // RAM stuck BUSY: timeout after 15 wait cycles
    drive(0,1,0, 0,32'h20,0, 0, BUSY,32'hFFFFFFFF);
    for (int k = 1; k <= 15; k++) begin
      drive(0,1,0, 0,32'h20,0, 0, BUSY,32'hFFFFFFFF);
      chk($sformatf("to c%0d ramREN", k), ramREN, 1);
      chk($sformatf("to c%0d dhit", k), dhit, 0);
      chk($sformatf("to c%0d mem_err", k), mem_err, 0);
    end
    drive(0,1,0, 0,32'h20,0, 0, BUSY,32'hFFFFFFFF);
    chk("to dhit", dhit, 1);
    chk("to dmemload", dmemload, 0);
    chk("to mem_err", mem_err, 1);
    chk("to ramREN", ramREN, 0);
    for (int k = 0; k < 3; k++) idle_cycle();
    chk("to err sticky", mem_err, 1);
    do_reset();
    chk("to err cleared", mem_err, 0);

    // Halt mid-access: access completes, then HALTED ignores everything
    drive(0,1,0, 0,32'h60,0, 0, FREE,0);
    drive(0,1,0, 0,32'h60,0, 1, BUSY,0);
    chk("halt ramREN c1", ramREN, 1);
    drive(0,1,0, 0,32'h60,0, 1, ACC,32'h99);
    chk("halt ramREN c2", ramREN, 1);
    drive(0,1,0, 0,32'h60,0, 1, FREE,0);
    chk("halt dhit", dhit, 1);
    chk("halt dmemload", dmemload, 32'h99);
    drive(1,1,0, 0,32'h60,0, 1, FREE,0);
    chk("halt idle dhit", dhit, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1,1,1, 32'h4,32'h60,32'h1, 0, ACC,32'h5);
      chk($sformatf("hlt%0d ihit", k), ihit, 0);
      chk($sformatf("hlt%0d dhit", k), dhit, 0);
      chk($sformatf("hlt%0d ramREN", k), ramREN, 0);
      chk($sformatf("hlt%0d ramWEN", k), ramWEN, 0);
    end
    do_reset();

    // Reset asserted mid-fetch: strobe drops at once, no ihit afterwards
    drive(1,0,0, 32'h80,0,0, 0, BUSY,0);
    drive(1,0,0, 32'h80,0,0, 0, BUSY,0);
    chk("rmid ramREN before", ramREN, 1);
    #1;
    RST = 1'b1;
    imemREN = 1'b0;
    ramstate = ACC;
    #1;
    chk("rmid ramREN after", ramREN, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0,0,0, 0,0,0, 0, ACC,32'h3);
      chk($sformatf("rmid%0d ihit", k), ihit, 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
